// File: rtl/doodle_pkg.sv
// Shared screen geometry, LFSR feedback mask and the platform-manager FSM states.
package doodle_pkg;

    localparam int unsigned ScreenW  = 640;
    localparam int unsigned ScreenH  = 480;
    localparam int unsigned PlatW    = 40;
    localparam int unsigned PlatH    = 8;
    localparam logic [15:0] LfsrMask = 16'hB400;

    typedef enum logic [2:0] {
        StIdle,
        StScroll,
        StRecycle,
        StCollide,
        StDone
    } state_e;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances once per enabled cycle; shared with the colour mapper.
module lfsr16
    import doodle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = LfsrMask
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ MASK) : (state_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/platform_field.sv
// Platform slot manager: per-frame scroll, recycle to the top at random X, landing search
// and saturating height score.
module platform_field
    import doodle_pkg::*;
#(
    parameter int unsigned NUM_PLATS = 15,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 10,
    parameter int unsigned SCREEN_W  = ScreenW,
    parameter int unsigned SCREEN_H  = ScreenH,
    parameter int unsigned PLAT_W    = PlatW,
    parameter int unsigned PLAT_H    = PlatH,
    parameter int unsigned SPAWN_GAP = 32,
    parameter int unsigned DOODLE_W  = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_clk,
    input  logic [7:0]               scroll_amt,
    input  logic [X_W-1:0]           doodle_x,
    input  logic [Y_W-1:0]           doodle_bot,
    input  logic                     doodle_falling,
    output logic [NUM_PLATS*X_W-1:0] plat_x,
    output logic [NUM_PLATS*Y_W-1:0] plat_y,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     land,
    output logic [4:0]               land_idx,
    output logic [Y_W-1:0]           land_y,
    output logic [15:0]              score,
    output logic                     overrun
);

    localparam int unsigned IdxW      = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1;
    localparam int unsigned XW1       = X_W + 1;
    localparam int unsigned YW1       = Y_W + 1;
    localparam int unsigned XSpan     = SCREEN_W - PLAT_W + 1;
    localparam int unsigned MaxScroll = SPAWN_GAP / 2;

    logic [X_W-1:0]  plat_x_q [NUM_PLATS];
    logic [Y_W-1:0]  plat_y_q [NUM_PLATS];
    logic [2:0]      sync_q;
    logic            tick;
    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q;
    logic            last_idx;
    logic [7:0]      scroll_q;
    logic [15:0]     score_q;
    logic [16:0]     score_sum;
    logic            overrun_q;
    logic            hit_found_q;
    logic [4:0]      land_idx_q;
    logic [Y_W-1:0]  land_y_q;
    logic [15:0]     lfsr;
    logic [X_W-1:0]  rand_r, rand_x;
    logic [X_W-1:0]  cur_x;
    logic [Y_W-1:0]  cur_y;
    logic            hit;
    logic            unused_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (LfsrMask)
    ) u_lfsr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .en    (1'b1),
        .state (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:X_W];

    // sync_q[1:0] is the synchroniser, sync_q[2] holds the previous value for edge detect.
    assign tick     = sync_q[1] & ~sync_q[2];
    assign last_idx = (idx_q == IdxW'(NUM_PLATS - 1));

    assign rand_r = lfsr[X_W-1:0];
    assign rand_x = (rand_r >= X_W'(XSpan)) ? (rand_r - X_W'(XSpan)) : rand_r;

    assign cur_x = plat_x_q[idx_q];
    assign cur_y = plat_y_q[idx_q];

    assign hit = doodle_falling
        && (({1'b0, doodle_x} + XW1'(DOODLE_W)) > {1'b0, cur_x})
        && ({1'b0, doodle_x} < ({1'b0, cur_x} + XW1'(PLAT_W)))
        && ({1'b0, cur_y} <= {1'b0, doodle_bot})
        && ({1'b0, doodle_bot} <= ({1'b0, cur_y} + YW1'(PLAT_H)));

    assign score_sum = {1'b0, score_q} + 17'(scroll_q);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (tick) state_d = StScroll;
            StScroll:  state_d = StRecycle;
            StRecycle: if (last_idx) state_d = StCollide;
            StCollide: if (last_idx) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
        land       = (state_q == StDone) && hit_found_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_PLATS; i++) begin
                plat_x_q[i] <= X_W'((i * 97) % XSpan);
                plat_y_q[i] <= Y_W'(SCREEN_H - PLAT_H - i * SPAWN_GAP);
            end
            sync_q      <= '0;
            idx_q       <= '0;
            scroll_q    <= '0;
            score_q     <= '0;
            overrun_q   <= 1'b0;
            hit_found_q <= 1'b0;
            land_idx_q  <= '0;
            land_y_q    <= '0;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk};
            if (tick && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (tick) begin
                        scroll_q    <= (scroll_amt > 8'(MaxScroll)) ? 8'(MaxScroll) : scroll_amt;
                        hit_found_q <= 1'b0;
                        idx_q       <= '0;
                    end
                end
                StScroll: begin
                    for (int i = 0; i < NUM_PLATS; i++) begin
                        plat_y_q[i] <= Y_W'({1'b0, plat_y_q[i]} + YW1'(scroll_q));
                    end
                    score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end
                StRecycle: begin
                    // Subtracting exactly SCREEN_H keeps the slot pitch intact modulo the screen.
                    if ({1'b0, cur_y} >= YW1'(SCREEN_H)) begin
                        plat_y_q[idx_q] <= cur_y - Y_W'(SCREEN_H);
                        plat_x_q[idx_q] <= rand_x;
                    end
                    idx_q <= last_idx ? '0 : idx_q + IdxW'(1);
                end
                StCollide: begin
                    if (hit && !hit_found_q) begin
                        hit_found_q <= 1'b1;
                        land_idx_q  <= 5'(idx_q);
                        land_y_q    <= cur_y;
                    end
                    idx_q <= last_idx ? '0 : idx_q + IdxW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PLATS; g++) begin : g_flat
        assign plat_x[g*X_W +: X_W] = plat_x_q[g];
        assign plat_y[g*Y_W +: Y_W] = plat_y_q[g];
    end

    assign land_idx = land_idx_q;
    assign land_y   = land_y_q;
    assign score    = score_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field: reset layout, scroll/recycle, landing, priority,
// clamp/saturation, overrun and mid-update reset.
module tb_platform_field;

    logic         Clk;
    logic         Reset_n;
    logic         frame_clk;
    logic [7:0]   scroll_amt;
    logic [9:0]   doodle_x;
    logic [9:0]   doodle_bot;
    logic         doodle_falling;
    logic [149:0] plat_x;
    logic [149:0] plat_y;
    logic         busy, frame_done, land, overrun;
    logic [4:0]   land_idx;
    logic [9:0]   land_y;
    logic [15:0]  score;

    logic [149:0] plat_x2, plat_y2;
    logic         busy2, frame_done2, land2, overrun2;
    logic [4:0]   land_idx2;
    logic [9:0]   land_y2;
    logic [15:0]  score2;

    int checks = 0;
    int errors = 0;

    platform_field dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_clk      (frame_clk),
        .scroll_amt     (scroll_amt),
        .doodle_x       (doodle_x),
        .doodle_bot     (doodle_bot),
        .doodle_falling (doodle_falling),
        .plat_x         (plat_x),
        .plat_y         (plat_y),
        .busy           (busy),
        .frame_done     (frame_done),
        .land           (land),
        .land_idx       (land_idx),
        .land_y         (land_y),
        .score          (score),
        .overrun        (overrun)
    );

    // Tall platforms and a wide doodle so that several slots overlap the doodle at once.
    platform_field #(
        .PLAT_H   (72),
        .DOODLE_W (300)
    ) dut2 (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_clk      (frame_clk),
        .scroll_amt     (scroll_amt),
        .doodle_x       (10'd300),
        .doodle_bot     (10'd316),
        .doodle_falling (1'b1),
        .plat_x         (plat_x2),
        .plat_y         (plat_y2),
        .busy           (busy2),
        .frame_done     (frame_done2),
        .land           (land2),
        .land_idx       (land_idx2),
        .land_y         (land_y2),
        .score          (score2),
        .overrun        (overrun2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [9:0] py(input int i);
        return plat_y[i*10 +: 10];
    endfunction

    function automatic logic [9:0] px(input int i);
        return plat_x[i*10 +: 10];
    endfunction

    task automatic do_reset();
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // Raises frame_clk and observes a fixed window long enough for one full update.
    task automatic run_frame(input logic [7:0] amt, output int busy_n, output int done_n,
                             output logic l, output logic [4:0] li, output logic [9:0] ly);
        busy_n = 0;
        done_n = 0;
        l  = 1'b0;
        li = '0;
        ly = '0;
        scroll_amt = amt;
        frame_clk  = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge Clk);
            if (busy) busy_n++;
            if (frame_done) begin
                done_n++;
                l  = land;
                li = land_idx;
                ly = land_y;
            end
        end
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (py(0) !== 10'd472) begin errors++; $display("FAIL reset_y0 got %0d want 472", py(0)); end
        checks++; if (py(14) !== 10'd24) begin errors++; $display("FAIL reset_y14 got %0d want 24", py(14)); end
        checks++; if (px(1) !== 10'd97) begin errors++; $display("FAIL reset_x1 got %0d want 97", px(1)); end
        checks++; if (px(7) !== 10'd78) begin errors++; $display("FAIL reset_x7 got %0d want 78", px(7)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if ({frame_done, land} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {frame_done, land}); end
        checks++; if ({land_idx, land_y} !== 15'd0) begin errors++; $display("FAIL reset_land got %0d/%0d want 0/0", land_idx, land_y); end
    endtask

    task automatic test_scroll();
        int bn, dn;
        logic l;
        logic [4:0] li;
        logic [9:0] ly;
        do_reset();
        doodle_x = 10'd100; doodle_bot = 10'd454; doodle_falling = 1'b1;
        run_frame(8'd10, bn, dn, l, li, ly);
        checks++; if (bn != 32) begin errors++; $display("FAIL scroll_busy_cycles got %0d want 32", bn); end
        checks++; if (dn != 1) begin errors++; $display("FAIL scroll_done_pulses got %0d want 1", dn); end
        checks++; if (py(0) !== 10'd2) begin errors++; $display("FAIL scroll_recycle_y0 got %0d want 2", py(0)); end
        checks++; if (px(0) > 10'd600) begin errors++; $display("FAIL scroll_recycle_x0 got %0d want <=600", px(0)); end
        checks++; if (py(1) !== 10'd450) begin errors++; $display("FAIL scroll_y1 got %0d want 450", py(1)); end
        checks++; if (py(14) !== 10'd34) begin errors++; $display("FAIL scroll_y14 got %0d want 34", py(14)); end
        checks++; if (score !== 16'd10) begin errors++; $display("FAIL scroll_score got %0d want 10", score); end
        checks++; if ({l, li, ly} !== {1'b1, 5'd1, 10'd450}) begin errors++; $display("FAIL scroll_land got %b/%0d/%0d want 1/1/450", l, li, ly); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scroll_idle_after got %b want 0", busy); end
    endtask

    task automatic test_land();
        // {doodle_x, doodle_bot, land expected, land_y expected}; slot 0 at (0,472), slot 1 at (97,440).
        logic [30:0] vec [9];
        int bn, dn;
        logic l;
        logic [4:0] li;
        logic [9:0] ly;
        vec[0] = {10'd10,  10'd476, 1'b1, 10'd472};
        vec[1] = {10'd100, 10'd444, 1'b1, 10'd440};
        vec[2] = {10'd137, 10'd444, 1'b0, 10'd0};
        vec[3] = {10'd136, 10'd444, 1'b1, 10'd440};
        vec[4] = {10'd65,  10'd444, 1'b0, 10'd0};
        vec[5] = {10'd66,  10'd444, 1'b1, 10'd440};
        vec[6] = {10'd100, 10'd448, 1'b1, 10'd440};
        vec[7] = {10'd100, 10'd449, 1'b0, 10'd0};
        vec[8] = {10'd100, 10'd439, 1'b0, 10'd0};
        do_reset();
        doodle_falling = 1'b1;
        for (int v = 0; v < 9; v++) begin
            doodle_x   = vec[v][30:21];
            doodle_bot = vec[v][20:11];
            run_frame(8'd0, bn, dn, l, li, ly);
            checks++;
            if (dn != 1 || l !== vec[v][10]) begin
                errors++;
                $display("FAIL land_vec%0d done=%0d land=%b want done=1 land=%b", v, dn, l, vec[v][10]);
            end
            if (vec[v][10]) begin
                checks++;
                if (ly !== vec[v][9:0] || li !== ((vec[v][9:0] == 10'd472) ? 5'd0 : 5'd1)) begin
                    errors++;
                    $display("FAIL land_pos%0d got %0d/%0d want y=%0d", v, li, ly, vec[v][9:0]);
                end
            end
        end
        checks++; if (land_idx !== 5'd1 || land_y !== 10'd440) begin errors++; $display("FAIL land_hold got %0d/%0d want 1/440", land_idx, land_y); end
        doodle_x = 10'd10; doodle_bot = 10'd476; doodle_falling = 1'b0;
        run_frame(8'd0, bn, dn, l, li, ly);
        checks++; if (l !== 1'b0) begin errors++; $display("FAIL land_not_falling got %b want 0", l); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL land_score_zero got %0d want 0", score); end
    endtask

    task automatic test_priority();
        int dn = 0;
        logic [4:0] li = '0;
        logic [9:0] ly = '0;
        logic l = 1'b0;
        do_reset();
        scroll_amt = 8'd0;
        frame_clk  = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge Clk);
            if (frame_done2) begin
                dn++;
                l = land2; li = land_idx2; ly = land_y2;
            end
        end
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        checks++; if (dn != 1 || l !== 1'b1) begin errors++; $display("FAIL prio_land got done=%0d land=%b want 1/1", dn, l); end
        checks++; if (li !== 5'd3 || ly !== 10'd312) begin errors++; $display("FAIL prio_idx got %0d/%0d want 3/312", li, ly); end
    endtask

    task automatic test_clamp_saturate();
        int bn, dn;
        logic l;
        logic [4:0] li;
        logic [9:0] ly;
        do_reset();
        doodle_falling = 1'b0;
        run_frame(8'd200, bn, dn, l, li, ly);
        checks++; if (score !== 16'd16) begin errors++; $display("FAIL clamp_score got %0d want 16", score); end
        checks++; if (py(1) !== 10'd456) begin errors++; $display("FAIL clamp_y1 got %0d want 456", py(1)); end
        checks++; if (py(0) !== 10'd8) begin errors++; $display("FAIL clamp_y0 got %0d want 8", py(0)); end
        force dut.score_q = 16'hFFF0;
        @(negedge Clk);
        release dut.score_q;
        run_frame(8'd14, bn, dn, l, li, ly);
        checks++; if (score !== 16'hFFFE) begin errors++; $display("FAIL sat_below got %h want fffe", score); end
        run_frame(8'd1, bn, dn, l, li, ly);
        checks++; if (score !== 16'hFFFF) begin errors++; $display("FAIL sat_exact got %h want ffff", score); end
        force dut.score_q = 16'hFFF8;
        @(negedge Clk);
        release dut.score_q;
        run_frame(8'd200, bn, dn, l, li, ly);
        checks++; if (score !== 16'hFFFF) begin errors++; $display("FAIL sat_over got %h want ffff", score); end
        run_frame(8'd5, bn, dn, l, li, ly);
        checks++; if (score !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", score); end
    endtask

    task automatic test_overrun_and_abort();
        int bn, dn;
        logic l;
        logic [4:0] li;
        logic [9:0] ly;
        do_reset();
        doodle_x = 10'd100; doodle_bot = 10'd450; doodle_falling = 1'b1;
        dn = 0;
        l  = 1'b0; li = '0; ly = '0;
        scroll_amt = 8'd5;
        frame_clk  = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge Clk);
            if (c == 4) frame_clk = 1'b0;
            if (c == 9) frame_clk = 1'b1;
            if (frame_done) begin
                dn++;
                l = land; li = land_idx; ly = land_y;
            end
        end
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
        checks++; if (dn != 1) begin errors++; $display("FAIL overrun_updates got %0d want 1", dn); end
        checks++; if (score !== 16'd5 || py(1) !== 10'd445) begin errors++; $display("FAIL overrun_single got %0d/%0d want 5/445", score, py(1)); end
        checks++; if ({l, li, ly} !== {1'b1, 5'd1, 10'd445}) begin errors++; $display("FAIL overrun_land got %b/%0d/%0d want 1/1/445", l, li, ly); end
        run_frame(8'd0, bn, dn, l, li, ly);
        checks++; if (overrun !== 1'b1 || dn != 1) begin errors++; $display("FAIL overrun_sticky got %b/%0d want 1/1", overrun, dn); end

        frame_clk  = 1'b1;
        scroll_amt = 8'd3;
        repeat (20) @(negedge Clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
        Reset_n = 1'b0;
        @(negedge Clk);
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || land !== 1'b0) begin errors++; $display("FAIL abort_ctrl got %b%b%b want 000", busy, frame_done, land); end
        checks++; if (score !== 16'd0 || overrun !== 1'b0) begin errors++; $display("FAIL abort_score got %0d/%b want 0/0", score, overrun); end
        checks++; if (land_idx !== 5'd0 || land_y !== 10'd0) begin errors++; $display("FAIL abort_land got %0d/%0d want 0/0", land_idx, land_y); end
        checks++; if (py(0) !== 10'd472 || py(1) !== 10'd440 || px(1) !== 10'd97) begin errors++; $display("FAIL abort_layout got %0d/%0d/%0d want 472/440/97", py(0), py(1), px(1)); end
        Reset_n   = 1'b1;
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        Reset_n        = 1'b0;
        frame_clk      = 1'b0;
        scroll_amt     = 8'd0;
        doodle_x       = 10'd0;
        doodle_bot     = 10'd0;
        doodle_falling = 1'b0;
        test_reset();
        test_scroll();
        test_land();
        test_priority();
        test_clamp_saturate();
        test_overrun_and_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
